// File: rtl/motor_pwm_driver.sv
// Converts 2-bit DriveA/DriveB movement codes into L298N-style H-bridge signals
// with soft-start ramping and dead time on direction reversal.
module motor_pwm_driver #(
    parameter int unsigned PERIOD       = 100,
    parameter int unsigned DUTY_SLOW    = 50,
    parameter int unsigned DUTY_FULL    = 100,
    parameter int unsigned DUTY_REV     = 60,
    parameter int unsigned RAMP_STEP    = 10,
    parameter int unsigned DEAD_PERIODS = 2
) (
    input  logic       ACLK,
    input  logic       ARESETn,
    input  logic [1:0] DriveA,
    input  logic [1:0] DriveB,
    output logic       ENA,
    output logic       IN1,
    output logic       IN2,
    output logic       ENB,
    output logic       IN3,
    output logic       IN4
);

    localparam int unsigned CW  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned DW  = $clog2(PERIOD + 1);
    localparam int unsigned XW  = DW + 1;
    localparam int unsigned DCW = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;

    // Direction values double as the {INx_fwd, INx_rev} bridge pair.
    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_FWD  = 2'b10;
    localparam logic [1:0] DIR_REV  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    typedef struct packed {
        state_t         st;
        logic [1:0]     dir;
        logic [DW-1:0]  duty;
        logic [DCW-1:0] dead;
    } chan_t;

    logic [CW-1:0] cnt_q, cnt_n;
    chan_t         cha_q, cha_n, chb_q, chb_n;
    logic          ena_n, enb_n;

    // Per-channel boundary update: ramp up, immediate ramp down, dead time on reversal.
    function automatic chan_t chan_next(input chan_t cur, input logic [1:0] code);
        chan_t          nxt;
        logic [1:0]     tdir;
        logic [XW-1:0]  tduty;
        logic [XW-1:0]  first;
        logic [XW-1:0]  ramp;
        nxt = cur;
        case (code)
            2'b01:   begin tdir = DIR_FWD;  tduty = XW'(DUTY_SLOW); end
            2'b10:   begin tdir = DIR_FWD;  tduty = XW'(DUTY_FULL); end
            2'b11:   begin tdir = DIR_REV;  tduty = XW'(DUTY_REV);  end
            default: begin tdir = DIR_NONE; tduty = '0;             end
        endcase
        first = (XW'(RAMP_STEP) < tduty) ? XW'(RAMP_STEP) : tduty;
        ramp  = XW'(cur.duty) + XW'(RAMP_STEP);
        if (ramp > tduty) begin
            ramp = tduty;
        end
        case (cur.st)
            ST_IDLE: begin
                if (tdir != DIR_NONE) begin
                    nxt.st   = ST_RUN;
                    nxt.dir  = tdir;
                    nxt.duty = DW'(first);
                end
            end
            ST_RUN: begin
                if (tdir == DIR_NONE) begin
                    nxt = '0;
                end else if (tdir != cur.dir) begin
                    nxt.st   = ST_DEAD;
                    nxt.dir  = DIR_NONE;
                    nxt.duty = '0;
                    nxt.dead = DCW'(DEAD_PERIODS - 1);
                end else if (tduty > XW'(cur.duty)) begin
                    nxt.duty = DW'(ramp);
                end else begin
                    nxt.duty = DW'(tduty);
                end
            end
            ST_DEAD: begin
                if (tdir == DIR_NONE) begin
                    nxt = '0;
                end else if (cur.dead != '0) begin
                    nxt.dead = cur.dead - DCW'(1);
                end else begin
                    nxt.st   = ST_RUN;
                    nxt.dir  = tdir;
                    nxt.duty = DW'(first);
                end
            end
            default: nxt = '0;
        endcase
        return nxt;
    endfunction

    // Next-state: shared period counter, boundary sampling, registered output values.
    always_comb begin
        cnt_n = cnt_q + CW'(1);
        cha_n = cha_q;
        chb_n = chb_q;
        if (cnt_q == CW'(PERIOD - 1)) begin
            cnt_n = '0;
            cha_n = chan_next(cha_q, DriveA);
            chb_n = chan_next(chb_q, DriveB);
        end
        ena_n = XW'(cnt_n) < XW'(cha_n.duty);
        enb_n = XW'(cnt_n) < XW'(chb_n.duty);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            cnt_q      <= '0;
            cha_q      <= '0;
            chb_q      <= '0;
            ENA        <= 1'b0;
            ENB        <= 1'b0;
            {IN1, IN2} <= DIR_NONE;
            {IN3, IN4} <= DIR_NONE;
        end else begin
            cnt_q      <= cnt_n;
            cha_q      <= cha_n;
            chb_q      <= chb_n;
            ENA        <= ena_n;
            ENB        <= enb_n;
            {IN1, IN2} <= cha_n.dir;
            {IN3, IN4} <= chb_n.dir;
        end
    end

endmodule
